clk_gen_ctrl: RTL and testbench
===============================

Name: clk_gen_ctrl

Overview:
- Programmable multi-channel clock generator and controller.
- Derives NCH 50%-duty divided clocks from one reference clock.
- Each channel's half-period, in reference-clock cycles, is set through a valid/ready config port.
- Period changes and enable/disable take effect only at a period boundary (falling edge of the channel output), so outputs are glitch-free. The bench and top level use it in place of free-running delay-based clocks.

Parameters:
- NCH, 3, number of output clock channels (1..4).
- HALF_W, 8, width of the half-period count; max half-period is 2^HALF_W-1 cycles.

Ports:
- clk  input  1  reference clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- cfg_valid  input  1  config request valid.
- cfg_ready  output  1  controller can accept a config request.
- cfg_ch  input  2  target channel index.
- cfg_en  input  1  1 = enable channel, 0 = disable.
- cfg_half  input  HALF_W  new half-period in clk cycles.
- clk_out  output  NCH  generated clocks, registered.
- rise_tick  output  NCH  1-cycle pulse, high in the same cycle clk_out[i] becomes 1.
- busy  output  1  a pending update is waiting for its boundary.
- cfg_err  output  1  1-cycle pulse: request rejected.

Behaviour:
- Reset: asserting rst clears immediately, regardless of clk, including mid-period and with a pending update. After reset:
  - every channel disabled; cnt=0, half=0, clk_out=0, rise_tick=0;
  - pending cleared; busy=0, cfg_ready=1, cfg_err=0.
- Enabled channel i, each clk edge:
  - if cnt==half-1: cnt<=0, clk_out[i] toggles;
  - else cnt<=cnt+1.
  - Period is 2*half cycles with exact 50% duty. half=1 gives clk/2.
- rise_tick[i] is registered alongside the 0->1 toggle; it is never high while the channel is disabled.
- Handshake:
  - A request is accepted on an edge where cfg_valid && cfg_ready.
  - cfg_ready = !busy. Only one update is outstanding at a time.
  - cfg_valid held without ready is not consumed.
- Rejection: if cfg_ch >= NCH, or cfg_en=1 with cfg_half=0:
  - cfg_err pulses high for exactly the cycle after acceptance;
  - no state change; busy stays 0.
  - A disable request (cfg_en=0) ignores cfg_half.
- Accepted request to a disabled channel: applied at the acceptance edge.
  - half<=cfg_half, en<=cfg_en, cnt<=0, clk_out stays 0; busy stays 0.
  - If enabled, the first rise occurs half cycles after the acceptance edge.
- Accepted request to an enabled channel: stored as pending; busy=1.
  - Applied at the first 1->0 toggle of that channel strictly after the acceptance edge. On that edge: half<=pending half, en<=pending en, cnt<=0, clk_out<=0, busy<=0.
  - If the request is a disable, the output stays 0 from that edge on.
  - The current period always completes with the old half. A 1->0 toggle on the acceptance edge itself does not apply the update.
- Other channels run unaffected by any config activity.
- Counters never exceed half-1. No wrap condition exists beyond the cnt==half-1 compare.

Test Plan:
- Reset, then enable ch0 with half=3 at edge E -> clk_out[0] rises at E+3, falls at E+6, period 6 cycles; rise_tick[0] high only in cycles E+3, E+9, ...
- ch0 running at half=3; request ch0 half=5 mid high phase -> busy=1, cfg_ready=0. At the next falling edge, clk_out=0, busy=0, then high/low phases of 5 cycles. No phase shorter than 3 cycles anywhere.
- Enable ch0 half=1, ch1 half=2, ch2 half=4 -> periods 2, 4, 8 cycles, concurrent. Over 64 cycles: 32, 16 and 8 rise_ticks respectively.
- Request cfg_ch=3, and separately ch1 en=1 half=0 -> cfg_err pulses 1 cycle each; clk_out and busy unchanged.
- Disable ch2 while its output is high -> output finishes the high phase, falls at the boundary, stays 0; rise_tick[2] stays 0 thereafter.
- Assert rst asynchronously mid-low-phase with busy=1 -> all outputs 0 and busy=0 before the next clk edge; cfg_ready=1 after release.

Source files
------------

// File: rtl/clk_gen_ctrl.sv
// Multi-channel 50%-duty clock divider; half-period/enable updates land only at a channel's falling edge.
// Outputs registered; one update may be pending at a time (cfg_ready = !busy).
module clk_gen_ctrl #(
    parameter int NCH    = 3,
    parameter int HALF_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_ch,
    input  logic              cfg_en,
    input  logic [HALF_W-1:0] cfg_half,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    rise_tick,
    output logic              busy,
    output logic              cfg_err
);

    logic [NCH-1:0]    en_q, en_d, clk_q, clk_d, rise_q, rise_d, tog;
    logic [HALF_W-1:0] half_q [NCH];
    logic [HALF_W-1:0] half_d [NCH];
    logic [HALF_W-1:0] cnt_q  [NCH];
    logic [HALF_W-1:0] cnt_d  [NCH];
    logic              busy_q, busy_d, err_q, err_d, pend_en_q, pend_en_d;
    logic [1:0]        pend_ch_q, pend_ch_d;
    logic [HALF_W-1:0] pend_half_q, pend_half_d;
    logic              accept, bad;

    assign accept = cfg_valid && !busy_q;
    assign bad    = (int'(cfg_ch) >= NCH) || (cfg_en && (cfg_half == '0));

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            tog[i] = en_q[i] && (cnt_q[i] == half_q[i] - HALF_W'(1));
        end
    end

    always_comb begin
        en_d        = en_q;
        clk_d       = clk_q;
        rise_d      = '0;
        half_d      = half_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        err_d       = accept && bad;
        pend_en_d   = pend_en_q;
        pend_ch_d   = pend_ch_q;
        pend_half_d = pend_half_q;
        for (int i = 0; i < NCH; i++) begin
            if (en_q[i]) begin
                if (tog[i]) begin
                    cnt_d[i]  = '0;
                    clk_d[i]  = ~clk_q[i];
                    rise_d[i] = ~clk_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + HALF_W'(1);
                end
            end
            // busy_q gates this, so a fall on the acceptance edge itself never applies the update
            if (busy_q && (pend_ch_q == 2'(i)) && tog[i] && clk_q[i]) begin
                half_d[i] = pend_half_q;
                en_d[i]   = pend_en_q;
                cnt_d[i]  = '0;
                clk_d[i]  = 1'b0;
                busy_d    = 1'b0;
            end
            if (accept && !bad && (cfg_ch == 2'(i))) begin
                if (!en_q[i]) begin
                    half_d[i] = cfg_half;
                    en_d[i]   = cfg_en;
                    cnt_d[i]  = '0;
                    clk_d[i]  = 1'b0;
                end else begin
                    pend_ch_d   = cfg_ch;
                    pend_en_d   = cfg_en;
                    pend_half_d = cfg_half;
                    busy_d      = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_q        <= '0;
            clk_q       <= '0;
            rise_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            pend_en_q   <= 1'b0;
            pend_ch_q   <= '0;
            pend_half_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                half_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
        end else begin
            en_q        <= en_d;
            clk_q       <= clk_d;
            rise_q      <= rise_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            pend_en_q   <= pend_en_d;
            pend_ch_q   <= pend_ch_d;
            pend_half_q <= pend_half_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cfg_ready = !busy_q;
    assign clk_out   = clk_q;
    assign rise_tick = rise_q;
    assign busy      = busy_q;
    assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_gen_ctrl.sv
// Directed bench for clk_gen_ctrl: request table plus hand-timed period/boundary/reset sequences.
module tb_clk_gen_ctrl;

    localparam int NCH    = 3;
    localparam int HALF_W = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_ch = '0;
    logic              cfg_en = 1'b0;
    logic [HALF_W-1:0] cfg_half = '0;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    rise_tick;
    logic              busy;
    logic              cfg_err;

    int checks   = 0;
    int failures = 0;

    clk_gen_ctrl #(.NCH(NCH), .HALF_W(HALF_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_en    (cfg_en),
        .cfg_half  (cfg_half),
        .clk_out   (clk_out),
        .rise_tick (rise_tick),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        logic       en;
        logic [7:0] half;
        logic       exp_err;
        logic       exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // advance one rising edge, land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] ch, input logic en, input logic [7:0] half);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_en    = en;
        cfg_half  = half;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vt [6];
        int   r0, r1, r2;
        bit   found, bad;

        vt[0] = '{ch: 2'd3, en: 1'b1, half: 8'd5, exp_err: 1'b1, exp_busy: 1'b0};
        vt[1] = '{ch: 2'd1, en: 1'b1, half: 8'd0, exp_err: 1'b1, exp_busy: 1'b0};
        vt[2] = '{ch: 2'd3, en: 1'b0, half: 8'd0, exp_err: 1'b1, exp_busy: 1'b0};
        vt[3] = '{ch: 2'd2, en: 1'b0, half: 8'd0, exp_err: 1'b0, exp_busy: 1'b0};
        vt[4] = '{ch: 2'd1, en: 1'b1, half: 8'd2, exp_err: 1'b0, exp_busy: 1'b0};
        vt[5] = '{ch: 2'd1, en: 1'b1, half: 8'd3, exp_err: 1'b0, exp_busy: 1'b1};

        // reset state
        do_reset();
        check("rst_clk_out", 32'(clk_out), 32'(0));
        check("rst_rise", 32'(rise_tick), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_ready", 32'(cfg_ready), 32'(1));
        check("rst_err", 32'(cfg_err), 32'(0));

        // request table from idle
        for (int i = 0; i < 6; i++) begin
            cfg(vt[i].ch, vt[i].en, vt[i].half);
            check($sformatf("tbl%0d_err", i), 32'(cfg_err), 32'(vt[i].exp_err));
            check($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vt[i].exp_busy));
            check($sformatf("tbl%0d_ready", i), 32'(cfg_ready), 32'(!vt[i].exp_busy));
            step();
            check($sformatf("tbl%0d_err_clr", i), 32'(cfg_err), 32'(0));
        end

        // enable ch0 half=3: rise E+3, fall E+6, rise E+9
        do_reset();
        cfg(2'd0, 1'b1, 8'd3);
        check("t1_k0", 32'({clk_out[0], rise_tick[0]}), 32'(0));
        for (int k = 1; k <= 12; k++) begin
            step();
            check($sformatf("t1_k%0d", k), 32'({clk_out[0], rise_tick[0]}),
                  32'({(k >= 3) && (((k - 3) / 3) % 2 == 0), (k == 3) || (k == 9)}));
        end

        // period change half 3 -> 5 accepted mid-high at E+4, lands at fall E+6
        do_reset();
        cfg(2'd0, 1'b1, 8'd3);
        for (int k = 1; k <= 3; k++) step();
        cfg(2'd0, 1'b1, 8'd5);
        check("t2_busy_k4", 32'(busy), 32'(1));
        check("t2_ready_k4", 32'(cfg_ready), 32'(0));
        check("t2_clk_k4", 32'(clk_out[0]), 32'(1));
        cfg_valid = 1'b1;
        cfg_ch    = 2'd3;
        cfg_en    = 1'b1;
        cfg_half  = 8'd1;
        for (int k = 5; k <= 25; k++) begin
            step();
            if (k == 5) cfg_valid = 1'b0;
            check($sformatf("t2_k%0d", k), 32'({clk_out[0], busy, cfg_err}),
                  32'({(k < 6) || (((k - 6) / 5) % 2 == 1), k < 6, 1'b0}));
        end
        // request landing on a falling edge waits for the next one
        cfg(2'd0, 1'b1, 8'd2);
        check("t2b_k26", 32'({clk_out[0], busy}), 32'(2'b01));
        for (int k = 27; k <= 40; k++) begin
            step();
            check($sformatf("t2b_k%0d", k), 32'({clk_out[0], busy}),
                  32'({((k >= 31) && (k <= 35)) || (k == 38) || (k == 39), k < 36}));
        end

        // three concurrent channels
        do_reset();
        cfg(2'd0, 1'b1, 8'd1);
        cfg(2'd1, 1'b1, 8'd2);
        cfg(2'd2, 1'b1, 8'd4);
        check("t3_busy", 32'(busy), 32'(0));
        r0 = 0; r1 = 0; r2 = 0;
        for (int k = 0; k < 64; k++) begin
            step();
            r0 += int'(rise_tick[0]);
            r1 += int'(rise_tick[1]);
            r2 += int'(rise_tick[2]);
        end
        check("t3_rise0", 32'(r0), 32'(32));
        check("t3_rise1", 32'(r1), 32'(16));
        check("t3_rise2", 32'(r2), 32'(8));

        // rejections while running leave channels untouched
        cfg(2'd3, 1'b1, 8'd5);
        check("t4_err_ch3", 32'({cfg_err, busy}), 32'(2'b10));
        step();
        check("t4_err_ch3_clr", 32'(cfg_err), 32'(0));
        cfg(2'd1, 1'b1, 8'd0);
        check("t4_err_half0", 32'({cfg_err, busy}), 32'(2'b10));
        r1 = 0;
        for (int k = 0; k < 16; k++) begin
            step();
            r1 += int'(rise_tick[1]);
        end
        check("t4_ch1_rises", 32'(r1), 32'(4));

        // disable ch2 during its high phase
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            step();
            found = rise_tick[2];
        end
        check("t5_wait_rise2", 32'(found), 32'(1));
        cfg(2'd2, 1'b0, 8'd0);
        check("t5_r1", 32'({clk_out[2], busy}), 32'(2'b11));
        step();
        step();
        check("t5_r3", 32'({clk_out[2], busy}), 32'(2'b11));
        step();
        check("t5_r4", 32'({clk_out[2], busy}), 32'(2'b00));
        bad = 1'b0;
        r0 = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (clk_out[2] || rise_tick[2]) bad = 1'b1;
            r0 += int'(rise_tick[0]);
        end
        check("t5_ch2_quiet", 32'(bad), 32'(0));
        check("t5_ch0_rises", 32'(r0), 32'(10));

        // async reset mid-low-phase with an update pending
        do_reset();
        cfg(2'd0, 1'b1, 8'd3);
        cfg(2'd1, 1'b1, 8'd4);
        for (int k = 2; k <= 6; k++) step();
        cfg(2'd0, 1'b1, 8'd4);
        check("t6_pre", 32'({clk_out, busy}), 32'({3'b010, 1'b1}));
        #2 rst = 1'b1;
        #1;
        check("t6_async", 32'({clk_out, rise_tick, busy, cfg_ready}), 32'({3'b000, 3'b000, 1'b0, 1'b1}));
        step();
        rst = 1'b0;
        step();
        check("t6_ready", 32'({cfg_ready, cfg_err}), 32'(2'b10));
        bad = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (clk_out != '0) bad = 1'b1;
        end
        check("t6_idle", 32'(bad), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
